// File: rtl/irrigation_sequencer_pkg.sv
// ============================================================================
// irrigation_sequencer_pkg : shared encodings for the irrigation sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package irrigation_sequencer_pkg;

  localparam int c_dwell_width = 8;

  typedef logic [c_dwell_width-1:0] dwell_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPLINK_ON = 3'd1,
    ST_DRIP_ON   = 3'd2,
    ST_GAP       = 3'd3,
    ST_LOCKOUT   = 3'd4
  } state_t;

  typedef enum logic {
    SRV_SPLINKER = 1'b0,
    SRV_DRIP     = 1'b1
  } served_t;

  // Dwell value seen during the final cycle of an N-cycle interval.
  function automatic dwell_t last_count(input int cycles);
    return dwell_t'(cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/irrigation_dwell_counter.sv
// ============================================================================
// irrigation_dwell_counter : saturating dwell counter, sync clear, async reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module irrigation_dwell_counter
  import irrigation_sequencer_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   i_clear,
  input  logic   i_enable,
  output dwell_t o_count
);

  dwell_t r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + dwell_t'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/irrigation_sequencer.sv
// ============================================================================
// irrigation_sequencer : arbitrates the shared supply between sprinkler and drip
// Revision: 1.0
// ============================================================================
`default_nettype none

module irrigation_sequencer
  import irrigation_sequencer_pkg::*;
#(
  parameter int MIN_ON_CYCLES    = 8,
  parameter int MAX_ON_CYCLES    = 64,
  parameter int GAP_CYCLES       = 4,
  parameter int LOCK_HOLD_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic splinker_request,
  input  logic drip_request,
  input  logic water_critical,
  input  logic sensor_error,
  output logic splinker_valve,
  output logic drip_valve,
  output logic lockout,
  output logic timeout_pulse
);

  localparam dwell_t c_min_last  = last_count(MIN_ON_CYCLES);
  localparam dwell_t c_max_last  = last_count(MAX_ON_CYCLES);
  localparam dwell_t c_gap_last  = last_count(GAP_CYCLES);
  localparam dwell_t c_lock_last = last_count(LOCK_HOLD_CYCLES);

  state_t  r_state;
  state_t  w_next_state;
  served_t r_last_served;
  served_t w_next_last_served;
  dwell_t  w_count;
  logic    w_fault;
  logic    w_timeout;
  logic    w_count_clear;
  logic    r_splinker_valve;
  logic    r_drip_valve;
  logic    r_lockout;
  logic    r_timeout_pulse;

  assign w_fault = water_critical | sensor_error;

  always_comb begin
    w_next_state       = r_state;
    w_next_last_served = r_last_served;
    w_timeout          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fault) begin
          w_next_state = ST_LOCKOUT;
        end else if (splinker_request && drip_request) begin
          // Tie goes to whoever was not served last.
          if (r_last_served == SRV_DRIP) begin
            w_next_state       = ST_SPLINK_ON;
            w_next_last_served = SRV_SPLINKER;
          end else begin
            w_next_state       = ST_DRIP_ON;
            w_next_last_served = SRV_DRIP;
          end
        end else if (splinker_request) begin
          w_next_state       = ST_SPLINK_ON;
          w_next_last_served = SRV_SPLINKER;
        end else if (drip_request) begin
          w_next_state       = ST_DRIP_ON;
          w_next_last_served = SRV_DRIP;
        end
      end
      ST_SPLINK_ON: begin
        if (w_fault) begin
          w_next_state = ST_LOCKOUT;
        end else if (w_count == c_max_last) begin
          w_next_state = ST_GAP;
          w_timeout    = 1'b1;
        end else if (!splinker_request && (w_count >= c_min_last)) begin
          w_next_state = ST_GAP;
        end
      end
      ST_DRIP_ON: begin
        if (w_fault) begin
          w_next_state = ST_LOCKOUT;
        end else if (w_count == c_max_last) begin
          w_next_state = ST_GAP;
          w_timeout    = 1'b1;
        end else if (!drip_request && (w_count >= c_min_last)) begin
          w_next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_fault) begin
          w_next_state = ST_LOCKOUT;
        end else if (w_count == c_gap_last) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (!w_fault && (w_count == c_lock_last)) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_LOCKOUT;
      end
    endcase
  end

  // Any fault cycle in lockout restarts the fault-free hold.
  assign w_count_clear = (w_next_state != r_state) ||
                         ((r_state == ST_LOCKOUT) && w_fault);

  irrigation_dwell_counter u_dwell_counter (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_count_clear),
    .i_enable (1'b1),
    .o_count  (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_last_served    <= SRV_DRIP;
      r_splinker_valve <= 1'b0;
      r_drip_valve     <= 1'b0;
      r_lockout        <= 1'b0;
      r_timeout_pulse  <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_last_served    <= w_next_last_served;
      r_splinker_valve <= (w_next_state == ST_SPLINK_ON);
      r_drip_valve     <= (w_next_state == ST_DRIP_ON);
      r_lockout        <= (w_next_state == ST_LOCKOUT);
      r_timeout_pulse  <= w_timeout;
    end
  end

  assign splinker_valve = r_splinker_valve;
  assign drip_valve     = r_drip_valve;
  assign lockout        = r_lockout;
  assign timeout_pulse  = r_timeout_pulse;

endmodule

`default_nettype wire

// File: tb/tb_irrigation_sequencer.sv
// ============================================================================
// tb_irrigation_sequencer : directed and random checks against a reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_irrigation_sequencer;

  localparam int MIN_ON = 8;
  localparam int MAX_ON = 64;
  localparam int GAP    = 4;
  localparam int HOLD   = 16;

  logic clk;
  logic rst;
  logic splinker_request;
  logic drip_request;
  logic water_critical;
  logic sensor_error;
  logic splinker_valve;
  logic drip_valve;
  logic lockout;
  logic timeout_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which valve is open (0 none, 1 sprinkler, 2 drip),
  // how long it has been open, remaining gap, lockout clear run.
  int m_open;
  int m_on;
  int m_gap;
  int m_run;
  int m_last;
  bit m_locked;
  bit m_pulse;

  irrigation_sequencer #(
    .MIN_ON_CYCLES    (MIN_ON),
    .MAX_ON_CYCLES    (MAX_ON),
    .GAP_CYCLES       (GAP),
    .LOCK_HOLD_CYCLES (HOLD)
  ) dut (
    .clock            (clk),
    .reset            (rst),
    .splinker_request (splinker_request),
    .drip_request     (drip_request),
    .water_critical   (water_critical),
    .sensor_error     (sensor_error),
    .splinker_valve   (splinker_valve),
    .drip_valve       (drip_valve),
    .lockout          (lockout),
    .timeout_pulse    (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_open   = 0;
    m_on     = 0;
    m_gap    = 0;
    m_run    = 0;
    m_last   = 2;
    m_locked = 1'b0;
    m_pulse  = 1'b0;
  endtask

  task automatic model_edge(input logic sr, input logic dr, input logic wc, input logic se);
    bit fault;
    bit req;
    fault   = wc | se;
    m_pulse = 1'b0;
    if (m_locked) begin
      if (fault) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == HOLD) begin
          m_locked = 1'b0;
          m_run    = 0;
        end
      end
    end else if (fault) begin
      m_locked = 1'b1;
      m_open   = 0;
      m_gap    = 0;
      m_run    = 0;
    end else if (m_open != 0) begin
      m_on++;
      req = (m_open == 1) ? sr : dr;
      if (m_on == MAX_ON) begin
        m_open  = 0;
        m_pulse = 1'b1;
        m_gap   = GAP;
      end else if (!req && m_on >= MIN_ON) begin
        m_open = 0;
        m_gap  = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      if (sr && dr)  m_open = (m_last == 2) ? 1 : 2;
      else if (sr)   m_open = 1;
      else if (dr)   m_open = 2;
      if (m_open != 0) begin
        m_last = m_open;
        m_on   = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_all(input string phase);
    check({phase, ".splinker_valve"}, splinker_valve, (m_open == 1));
    check({phase, ".drip_valve"},     drip_valve,     (m_open == 2));
    check({phase, ".lockout"},        lockout,        m_locked);
    check({phase, ".timeout_pulse"},  timeout_pulse,  m_pulse);
    check({phase, ".exclusive"},      splinker_valve & drip_valve, 1'b0);
  endtask

  task automatic step(input string phase, input logic sr, input logic dr,
                      input logic wc, input logic se);
    splinker_request = sr;
    drip_request     = dr;
    water_critical   = wc;
    sensor_error     = se;
    @(posedge clk);
    model_edge(sr, dr, wc, se);
    #1;
    check_all(phase);
  endtask

  initial begin
    logic sr;
    logic dr;
    rst              = 1'b1;
    splinker_request = 1'b0;
    drip_request     = 1'b0;
    water_critical   = 1'b0;
    sensor_error     = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Short request is stretched to the minimum on-time, then gap, then idle.
    for (int i = 0; i < 3; i++)  step("min_on", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("min_on", 1'b0, 1'b0, 1'b0, 1'b0);

    // Both held: alternating timeouts.
    for (int i = 0; i < 150; i++) step("round_robin", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)  step("drain", 1'b0, 1'b0, 1'b0, 1'b0);

    // Fault in the middle of a drip interval, then a clean hold.
    for (int i = 0; i < 21; i++) step("drip_run", 1'b0, 1'b1, 1'b0, 1'b0);
    step("fault_on", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step("fault_hold", 1'b0, 1'b0, 1'b0, 1'b0);

    // Hold restart by a one-cycle sensor error pulse.
    step("restart_fault", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step("restart_clear", 1'b0, 1'b0, 1'b0, 1'b0);
    step("restart_pulse", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step("restart_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("drain", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset partway through a sprinkler interval.
    for (int i = 0; i < 31; i++) step("spl_run", 1'b1, 1'b0, 1'b0, 1'b0);
    splinker_request = 1'b1;
    drip_request     = 1'b1;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) step("tie_after_reset", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("drain", 1'b0, 1'b0, 1'b0, 1'b0);

    // Fault and grant in the same idle cycle.
    step("fault_grant", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step("fault_grant_hold", 1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic with persistent requests and rare faults.
    sr = 1'b0;
    dr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) sr = ~sr;
      if ($urandom_range(0, 9) == 0) dr = ~dr;
      step("random", sr, dr,
           ($urandom_range(0, 149) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
